// File: rtl/booth_pkg.sv
// booth_pkg: FSM state encoding and sizing helper shared by
// the sequential radix-2 Booth multiplier and its datapath step.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(v)) for v >= 1, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v)
        r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth step.
// Ports: acc/q/e current {A,Q,E}, y multiplicand (WIDTH+1 bits),
//        acc_nxt/q_nxt/e_nxt state after add/sub and arithmetic shift.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH+1:0] acc,
  input  logic [WIDTH:0]   q,
  input  logic             e,
  input  logic [WIDTH:0]   y,
  output logic [WIDTH+1:0] acc_nxt,
  output logic [WIDTH:0]   q_nxt,
  output logic             e_nxt
);

  logic [WIDTH+1:0] ys;
  logic [WIDTH+1:0] sum;

  // The extra guard bit keeps A - Y in range when
  // Y is the most-negative value.
  assign ys = {y[WIDTH], y};

  always_comb begin
    sum = acc;
    unique case (1'b1)
      q[0] & ~e: sum = acc - ys;
      ~q[0] & e: sum = acc + ys;
      default:   sum = acc;
    endcase
  end

  assign acc_nxt = {sum[WIDTH+1], sum[WIDTH+1:1]};
  assign q_nxt   = {sum[0], q[WIDTH:1]};
  assign e_nxt   = q[0];

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier, WIDTH+1 steps.
// Ports: in_valid/in_ready/in_x/in_y/in_signed operand handshake,
//        out_valid/out_ready/out_p product handshake, busy in RUN/DONE.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int CW = clog2(WIDTH + 2);

  state_t           state;
  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] acc_nxt;
  logic [WIDTH:0]   xq;
  logic [WIDTH:0]   q_nxt;
  logic [WIDTH:0]   yq;
  logic             e;
  logic             e_nxt;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [WIDTH:0]   x_ext;
  logic [WIDTH:0]   y_ext;

  // Signed mode sign-extends, unsigned mode zero-extends,
  // so one signed Booth datapath serves both.
  assign x_ext = {in_signed & in_x[WIDTH-1], in_x};
  assign y_ext = {in_signed & in_y[WIDTH-1], in_y};

  assign last = (cnt == CW'(WIDTH));

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc     (acc),
    .q       (xq),
    .e       (e),
    .y       (yq),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt),
    .e_nxt   (e_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      xq        <= '0;
      yq        <= '0;
      e         <= 1'b0;
      cnt       <= '0;
      out_p     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            xq       <= x_ext;
            yq       <= y_ext;
            acc      <= '0;
            e        <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          xq  <= q_nxt;
          e   <= e_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            // Low 2*WIDTH bits of {A,Q} after the final shift.
            out_p     <= {acc_nxt[WIDTH-2:0], q_nxt};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed table, corner sequences and random
// stall traffic for booth_mul_seq at WIDTH=16 and WIDTH=8.
module tb_booth_mul_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v16, ir16, s16, ov16, or16, bz16;
  logic [15:0] x16, y16;
  logic [31:0] p16;

  logic        v8, ir8, s8, ov8, or8, bz8;
  logic [7:0]  x8, y8;
  logic [15:0] p8;

  booth_mul_seq #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v16),
    .in_ready  (ir16),
    .in_x      (x16),
    .in_y      (y16),
    .in_signed (s16),
    .out_valid (ov16),
    .out_ready (or16),
    .out_p     (p16),
    .busy      (bz16)
  );

  booth_mul_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v8),
    .in_ready  (ir8),
    .in_x      (x8),
    .in_y      (y8),
    .in_signed (s8),
    .out_valid (ov8),
    .out_ready (or8),
    .out_p     (p8),
    .busy      (bz8)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    bit          s;
    logic [31:0] p;
  } vec_t;

  vec_t vt[10];

  logic [31:0] q16[$];
  logic [15:0] q8[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plain-arithmetic reference: interpret operands per mode, multiply,
  // keep the low 2*w bits.
  function automatic logic [63:0] refp(input logic [31:0] x,
                                       input logic [31:0] y,
                                       input bit s, input int w);
    longint a, b, m;
    logic [63:0] r;
    m = (longint'(1) << w) - 1;
    a = longint'(x) & m;
    b = longint'(y) & m;
    if (s && x[w-1]) a = a - (longint'(1) << w);
    if (s && y[w-1]) b = b - (longint'(1) << w);
    r = 64'(a * b);
    return r & ((64'd1 << (2 * w)) - 1);
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] r;
    logic [31:0] one;
    one = 32'd1;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r = one << (w - 1);
      1: r = '1;
      2: r = '0;
      3: r = (one << (w - 1)) - 1;
      default: ;
    endcase
    return r & ((one << w) - 1);
  endfunction

  task automatic mul16(input logic [15:0] x, input logic [15:0] y,
                       input bit s, output logic [31:0] p,
                       output int lat);
    int n;
    x16 = x; y16 = y; s16 = s; v16 = 1'b1; or16 = 1'b0;
    n = 0;
    while (!ir16 && n < 50) begin step(); n++; end
    if (!ir16) chk("mul16_accept", {63'd0, ir16}, 64'd1);
    step();
    v16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 100) begin step(); lat++; end
    p = p16;
    or16 = 1'b1;
    step();
    or16 = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    int lat;
    int n;
    int t[$];

    vt[0] = '{16'd3,    16'hFFFB, 1'b1, 32'hFFFFFFF1};
    vt[1] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vt[2] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000};
    vt[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vt[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vt[5] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001};
    vt[6] = '{16'h0000, 16'h1234, 1'b0, 32'h00000000};
    vt[7] = '{16'h8000, 16'h8000, 1'b0, 32'h40000000};
    vt[8] = '{16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF};
    vt[9] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};

    rst_n = 1'b0;
    v16 = 0; s16 = 0; or16 = 0; x16 = '0; y16 = '0;
    v8  = 0; s8  = 0; or8  = 0; x8  = '0; y8  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov16",  {63'd0, ov16}, 64'd0);
    chk("rst_p16",   {32'd0, p16},  64'd0);
    chk("rst_busy16", {63'd0, bz16}, 64'd0);
    chk("rst_rdy16", {63'd0, ir16}, 64'd0);
    chk("rst_ov8",   {63'd0, ov8},  64'd0);
    chk("rst_p8",    {48'd0, p8},   64'd0);
    rst_n = 1'b1;
    step();
    chk("rdy16_after_rst", {63'd0, ir16}, 64'd1);
    chk("rdy8_after_rst",  {63'd0, ir8},  64'd1);

    for (int i = 0; i < 10; i++) begin
      mul16(vt[i].x, vt[i].y, vt[i].s, p, lat);
      chk($sformatf("vec%0d_p", i), {32'd0, p}, {32'd0, vt[i].p});
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd17);
    end

    // Consumer stalls 10 cycles in DONE while in_valid toggles.
    x16 = 16'd1234; y16 = 16'd5; s16 = 1'b0; v16 = 1'b1; or16 = 1'b0;
    step();
    v16 = 1'b0;
    n = 0;
    while (!ov16 && n < 100) begin step(); n++; end
    chk("stall_lat", 64'(n), 64'd17);
    for (int i = 0; i < 10; i++) begin
      v16 = ~v16;
      x16 = 16'($urandom);
      y16 = 16'($urandom);
      s16 = ~s16;
      step();
      chk("stall_p",   {32'd0, p16},  64'd6170);
      chk("stall_ov",  {63'd0, ov16}, 64'd1);
      chk("stall_rdy", {63'd0, ir16}, 64'd0);
    end
    v16 = 1'b0;
    or16 = 1'b1;
    step();
    or16 = 1'b0;
    chk("release_ov",   {63'd0, ov16}, 64'd0);
    chk("release_rdy",  {63'd0, ir16}, 64'd1);
    chk("release_busy", {63'd0, bz16}, 64'd0);
    chk("release_keep_p", {32'd0, p16}, 64'd6170);
    step();
    chk("release_idle_busy", {63'd0, bz16}, 64'd0);

    // Back-to-back products with both valid and ready held high.
    x16 = 16'd300; y16 = 16'd7; s16 = 1'b0; v16 = 1'b1; or16 = 1'b1;
    for (int c = 0; c < 70; c++) begin
      step();
      if (ov16) begin
        t.push_back(c);
        chk("thru_p", {32'd0, p16}, 64'd2100);
      end
    end
    v16 = 1'b0;
    n = 0;
    while (bz16 && n < 50) begin step(); n++; end
    or16 = 1'b0;
    chk("thru_cnt", 64'(t.size()), 64'd3);
    if (t.size() >= 2)
      chk("thru_gap", 64'(t[1] - t[0]), 64'd19);

    // Reset pulse in the middle of RUN.
    x16 = 16'd100; y16 = 16'd200; s16 = 1'b0; v16 = 1'b1;
    step();
    v16 = 1'b0;
    repeat (7) step();
    chk("midrst_busy_pre", {63'd0, bz16}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ov",   {63'd0, ov16}, 64'd0);
    chk("midrst_p",    {32'd0, p16},  64'd0);
    chk("midrst_busy", {63'd0, bz16}, 64'd0);
    chk("midrst_rdy",  {63'd0, ir16}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    mul16(16'd7, 16'd6, 1'b0, p, lat);
    chk("midrst_next_p",   {32'd0, p}, 64'd42);
    chk("midrst_next_lat", 64'(lat), 64'd17);

    // Random traffic with stalls on both widths.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [31:0] a, b;
          bit s;
          int w;
          a = pick(16);
          b = pick(16);
          s = 1'($urandom_range(0, 1));
          x16 = a[15:0]; y16 = b[15:0]; s16 = s; v16 = 1'b1;
          w = 0;
          while (!ir16 && w < 200) begin step(); w++; end
          if (!ir16) begin
            chk("rnd16_accept", {63'd0, ir16}, 64'd1);
            break;
          end
          step();
          v16 = 1'b0;
          x16 = 16'($urandom);
          q16.push_back(refp(a, b, s, 16) & 64'hFFFF_FFFF);
          repeat ($urandom_range(0, 2)) step();
        end
      end
      begin
        int got, cyc;
        got = 0; cyc = 0;
        while (got < 1000 && cyc < 40000) begin
          or16 = ($urandom_range(0, 3) != 0);
          if (ov16 && or16) begin
            if (q16.size() == 0)
              chk("rnd16_extra", {63'd0, ov16}, 64'd0);
            else
              chk("rnd16_p", {32'd0, p16}, {32'd0, q16.pop_front()});
            got++;
          end
          step();
          cyc++;
        end
        or16 = 1'b0;
        chk("rnd16_count", 64'(got), 64'd1000);
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [31:0] a, b;
          bit s;
          int w;
          a = pick(8);
          b = pick(8);
          s = 1'($urandom_range(0, 1));
          x8 = a[7:0]; y8 = b[7:0]; s8 = s; v8 = 1'b1;
          w = 0;
          while (!ir8 && w < 200) begin step(); w++; end
          if (!ir8) begin
            chk("rnd8_accept", {63'd0, ir8}, 64'd1);
            break;
          end
          step();
          v8 = 1'b0;
          y8 = 8'($urandom);
          q8.push_back(16'(refp(a, b, s, 8)));
          repeat ($urandom_range(0, 2)) step();
        end
      end
      begin
        int got, cyc;
        got = 0; cyc = 0;
        while (got < 1000 && cyc < 40000) begin
          or8 = ($urandom_range(0, 3) != 0);
          if (ov8 && or8) begin
            if (q8.size() == 0)
              chk("rnd8_extra", {63'd0, ov8}, 64'd0);
            else
              chk("rnd8_p", {48'd0, p8}, {48'd0, q8.pop_front()});
            got++;
          end
          step();
          cyc++;
        end
        or8 = 1'b0;
        chk("rnd8_count", 64'(got), 64'd1000);
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
